// File: rtl/looper_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : looper_pkg                                               |
// | Description : Types and defaults shared by the looper control front    |
// |               end and the looper datapath.                             |
// |               - state_t : controller state, also drives the LEDs       |
// |               - c_DEFAULT_ADDR_WIDTH : loop memory address width       |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package looper_pkg;

  // Loop memory holds 2**c_DEFAULT_ADDR_WIDTH samples.
  localparam int c_DEFAULT_ADDR_WIDTH = 15;

  // Encoding is visible on the LED port, so values are pinned explicitly.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage : looper_pkg
`default_nettype wire

// File: rtl/looper_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : looper_ctrl_if                                           |
// | Description : Handshake between the looper controller, the codec      |
// |               sample strobe and the looper datapath.                   |
// |   sample_tick  codec -> ctrl   one-cycle strobe per audio sample       |
// |   write        ctrl  -> dp     record level                            |
// |   read         ctrl  -> dp     playback level                          |
// |   reverse      ctrl  -> dp     reverse-playback level                  |
// |   rw_step      ctrl  -> dp     advance looper address this cycle       |
// |   loop_len     ctrl  -> dp     recorded length, 0 = no loop            |
// |   loop_exists  ctrl  -> dp     loop_len is nonzero                     |
// |   state        ctrl  -> LEDs   current controller state                |
// | Modports    : master = controller, slave = datapath / observer         |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface looper_ctrl_if #(
  parameter int ADDR_WIDTH = looper_pkg::c_DEFAULT_ADDR_WIDTH
);

  logic                  sample_tick;
  logic                  write;
  logic                  read;
  logic                  reverse;
  logic                  rw_step;
  logic [ADDR_WIDTH:0]   loop_len;
  logic                  loop_exists;
  logic [1:0]            state;

  modport master (
    input  sample_tick,
    output write,
    output read,
    output reverse,
    output rw_step,
    output loop_len,
    output loop_exists,
    output state
  );

  // The datapath only observes; sample_tick comes from the codec.
  modport slave (
    input  sample_tick,
    input  write,
    input  read,
    input  reverse,
    input  rw_step,
    input  loop_len,
    input  loop_exists,
    input  state
  );

endinterface : looper_ctrl_if
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : key_debounce                                             |
// | Description : Two-flop synchronizer, hold-time debounce and rising    |
// |               edge press pulse for one raw pushbutton.                 |
// |   clk      in   system clock                                           |
// |   reset    in   asynchronous active-low reset                          |
// |   i_key    in   raw active-high key, asynchronous to clk               |
// |   o_press  out  one-cycle pulse on each accepted press                 |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key,
  output logic o_press
);

  // A counter that must reach DEBOUNCE_CYCLES-1; keep at least one bit so a
  // single-cycle debounce still elaborates.
  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_level_d;
  logic               r_press;
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_key;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // Any cycle agreeing with the accepted level restarts the hold count,
      // so a bounce cannot accumulate across glitches.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule : key_debounce
`default_nettype wire

// File: rtl/looper_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : looper_ctrl                                              |
// | Description : Looper control front end. Debounces the record, play    |
// |               and reverse keys, runs the IDLE/RECORD/PLAY/STOP state   |
// |               machine, tracks loop length and issues the per-sample    |
// |               address step to the looper datapath.                     |
// |   clk       in   system clock                                          |
// |   reset     in   asynchronous active-low reset                         |
// |   key_rec   in   raw record key                                        |
// |   key_play  in   raw play/stop key                                     |
// |   key_rev   in   raw reverse toggle key                                |
// |   lp        if   looper_ctrl_if.master (tick in, levels/len/state out) |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module looper_ctrl
  import looper_pkg::*;
#(
  parameter int ADDR_WIDTH      = c_DEFAULT_ADDR_WIDTH,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_rec,
  input  logic          key_play,
  input  logic          key_rev,
  looper_ctrl_if.master lp
);

  // Full loop: exactly 2**ADDR_WIDTH samples.
  localparam logic [ADDR_WIDTH:0] c_MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  // ---------------------------------------------------------------------
  // Key conditioning: bit 0 = rec, bit 1 = play, bit 2 = rev
  // ---------------------------------------------------------------------
  logic [2:0] w_keys;
  logic [2:0] w_press;
  logic       w_rec_press;
  logic       w_play_press;
  logic       w_rev_press;

  assign w_keys = {key_rev, key_play, key_rec};

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .i_key   (w_keys[gi]),
      .o_press (w_press[gi])
    );
  end

  assign w_rec_press  = w_press[0];
  assign w_play_press = w_press[1];
  assign w_rev_press  = w_press[2];

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   w_len_next;
  logic [ADDR_WIDTH-1:0] r_pos;
  logic [ADDR_WIDTH-1:0] w_pos_next;
  logic                  r_reverse;
  logic                  w_reverse_next;
  logic                  r_write;
  logic                  r_read;
  logic                  r_rw_step;
  logic                  r_loop_exists;
  logic                  w_stepping;

  // A tick steps under the state it arrives in, even if a press moves the
  // state on the same edge.
  assign w_stepping = lp.sample_tick && ((r_state == RECORD) || (r_state == PLAY));

  always_comb begin
    w_state_next   = r_state;
    w_len_next     = r_len;
    w_pos_next     = r_pos;
    w_reverse_next = r_reverse;

    // Effect of this cycle's sample under the current state.
    case (r_state)
      RECORD: begin
        if (lp.sample_tick) begin
          w_pos_next = r_pos + 1'b1;
          // Fresh take: pos tracks len so every sample grows the loop.
          // Overdub: only samples past the old end grow it, so an overdub
          // never shortens the loop.
          if (({1'b0, r_pos} >= r_len) && (r_len != c_MAX_LEN)) begin
            w_len_next = r_len + 1'b1;
          end
        end
      end
      PLAY: begin
        if (lp.sample_tick) begin
          if (({1'b0, r_pos} + 1'b1) >= r_len) begin
            w_pos_next = '0;
          end else begin
            w_pos_next = r_pos + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Transitions; rec outranks play, rev is handled on its own.
    case (r_state)
      IDLE: begin
        if (w_rec_press) begin
          w_state_next = RECORD;
          w_len_next   = '0;
        end
      end
      RECORD: begin
        // Auto-stop only on the sample that fills the memory; an overdub of
        // an already full loop keeps recording until a key is pressed.
        if (w_rec_press || w_play_press ||
            ((w_len_next == c_MAX_LEN) && (r_len != c_MAX_LEN))) begin
          // Length includes a sample taken on the leaving edge.
          w_state_next = (w_len_next == '0) ? IDLE : PLAY;
        end
      end
      PLAY: begin
        if (w_rec_press) begin
          w_state_next = RECORD;
        end else if (w_play_press) begin
          w_state_next = STOP;
        end
        if (w_rev_press) begin
          w_reverse_next = ~r_reverse;
        end
      end
      STOP: begin
        if (w_rec_press) begin
          w_state_next = RECORD;
          w_len_next   = '0;
        end else if (w_play_press) begin
          w_state_next = PLAY;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Every entry into RECORD restarts the step index and drops reverse.
    if ((w_state_next == RECORD) && (r_state != RECORD)) begin
      w_pos_next     = '0;
      w_reverse_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_pos         <= '0;
      r_reverse     <= 1'b0;
      r_write       <= 1'b0;
      r_read        <= 1'b0;
      r_rw_step     <= 1'b0;
      r_loop_exists <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_len         <= w_len_next;
      r_pos         <= w_pos_next;
      r_reverse     <= w_reverse_next;
      // Both levels come from the same next-state value, so RECORD<->PLAY
      // swaps them on one edge and they can never overlap.
      r_write       <= (w_state_next == RECORD);
      r_read        <= (w_state_next == PLAY);
      r_rw_step     <= w_stepping;
      r_loop_exists <= (w_len_next != '0);
    end
  end

  assign lp.write       = r_write;
  assign lp.read        = r_read;
  assign lp.reverse     = r_reverse;
  assign lp.rw_step     = r_rw_step;
  assign lp.loop_len    = r_len;
  assign lp.loop_exists = r_loop_exists;
  assign lp.state       = r_state;

endmodule : looper_ctrl
`default_nettype wire

// File: tb/tb_looper_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_looper_ctrl                                           |
// | Description : Self-checking bench for looper_ctrl: directed vector    |
// |               table, hand sequences for reset/bounce/auto-stop, and a  |
// |               random key phase against a cycle reference model.        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_looper_ctrl;

  localparam int AW   = 3;
  localparam int DB   = 4;
  localparam int MAXL = 8;
  localparam int LW   = AW + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic key_rec  = 1'b0;
  logic key_play = 1'b0;
  logic key_rev  = 1'b0;

  looper_ctrl_if #(.ADDR_WIDTH(AW)) lp();

  looper_ctrl #(
    .ADDR_WIDTH      (AW),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_rec  (key_rec),
    .key_play (key_play),
    .key_rev  (key_rev),
    .lp       (lp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit tick_en = 1'b0;

  // ---------------- reference model ----------------
  int       m_state, m_len, m_pos;
  bit       m_rev;
  bit [2:0] m_sync1, m_sync2, m_lvl, m_lvl_d, m_press;
  int       m_run [3];
  bit       e_write, e_read, e_step, e_exists;

  task automatic model_reset();
    m_state = 0; m_len = 0; m_pos = 0; m_rev = 1'b0;
    m_sync1 = '0; m_sync2 = '0; m_lvl = '0; m_lvl_d = '0; m_press = '0;
    for (int k = 0; k < 3; k++) m_run[k] = 0;
    e_write = 1'b0; e_read = 1'b0; e_step = 1'b0; e_exists = 1'b0;
  endtask

  // Advance the model over one rising edge with the given inputs.
  task automatic model_edge(input logic [2:0] keys, input logic tick);
    int st, ns, len, pos;
    bit rev, pr, pp, pv;
    st = m_state; len = m_len; pos = m_pos; rev = m_rev;
    pr = m_press[0]; pp = m_press[1]; pv = m_press[2];
    e_step = tick && (st == 1 || st == 2);
    if (tick && st == 1) begin
      if (pos >= len && len < MAXL) len = len + 1;
      pos = (pos + 1) % MAXL;
    end else if (tick && st == 2) begin
      pos = (pos + 1 >= len) ? 0 : pos + 1;
    end
    ns = st;
    case (st)
      0: if (pr) begin ns = 1; len = 0; end
      1: if (pr || pp || (len == MAXL && m_len < MAXL)) ns = (len == 0) ? 0 : 2;
      2: begin
        if (pr) ns = 1; else if (pp) ns = 3;
        if (pv) rev = !rev;
      end
      default: if (pr) begin ns = 1; len = 0; end else if (pp) ns = 2;
    endcase
    if (ns == 1 && st != 1) begin pos = 0; rev = 1'b0; end
    m_state = ns; m_len = len; m_pos = pos; m_rev = rev;
    e_write = (ns == 1); e_read = (ns == 2); e_exists = (len != 0);
    for (int k = 0; k < 3; k++) begin
      m_press[k] = m_lvl[k] & ~m_lvl_d[k];
      m_lvl_d[k] = m_lvl[k];
      if (m_sync2[k] == m_lvl[k]) m_run[k] = 0;
      else begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] == DB) begin m_lvl[k] = ~m_lvl[k]; m_run[k] = 0; end
      end
      m_sync2[k] = m_sync1[k];
      m_sync1[k] = keys[k];
    end
  endtask

  // ---------------- checks ----------------
  task automatic check_model();
    checks++;
    if (lp.state !== 2'(m_state) || lp.loop_len !== LW'(m_len) || lp.write !== e_write ||
        lp.read !== e_read || lp.reverse !== m_rev || lp.rw_step !== e_step ||
        lp.loop_exists !== e_exists) begin
      errors++;
      $display("FAIL model cyc=%0d: got st=%0d len=%0d w=%b r=%b rev=%b step=%b ex=%b, expected st=%0d len=%0d w=%b r=%b rev=%b step=%b ex=%b",
               cyc, lp.state, lp.loop_len, lp.write, lp.read, lp.reverse, lp.rw_step, lp.loop_exists,
               m_state, m_len, e_write, e_read, m_rev, e_step, e_exists);
    end
  endtask

  task automatic check_exp(input string name, input int st, input int len,
                           input bit w, input bit r, input bit rev, input bit ex);
    checks++;
    if (lp.state !== 2'(st) || lp.loop_len !== LW'(len) || lp.write !== w ||
        lp.read !== r || lp.reverse !== rev || lp.loop_exists !== ex) begin
      errors++;
      $display("FAIL %s: got st=%0d len=%0d w=%b r=%b rev=%b ex=%b, expected st=%0d len=%0d w=%b r=%b rev=%b ex=%b",
               name, lp.state, lp.loop_len, lp.write, lp.read, lp.reverse, lp.loop_exists,
               st, len, w, r, rev, ex);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_keys(input logic [2:0] m);
    key_rec = m[0]; key_play = m[1]; key_rev = m[2];
  endtask

  // One clock: drive the tick, step the model, cross the edge, compare.
  task automatic cycle();
    logic t;
    t = tick_en && (cyc % 3 == 0);
    lp.sample_tick = t;
    model_edge({key_rev, key_play, key_rec}, t);
    @(posedge clk);
    #1;
    cyc++;
    check_model();
  endtask

  // Clean press: long enough to be accepted, then released and settled.
  task automatic press_key(input int k);
    set_keys(3'b001 << k);
    repeat (DB + 2) cycle();
    set_keys(3'b000);
    repeat (DB + 6) cycle();
  endtask

  typedef struct {
    int ticks; int key; int st; int len; bit w; bit r; bit rev; bit ex;
  } vec_t;

  vec_t vec [17];

  initial begin
    int ntick;
    // key: 0 rec, 1 play, 2 rev; ticks are taken before the press
    vec[0]  = '{0, 0, 1, 0, 1, 0, 0, 0};  // IDLE rec -> RECORD
    vec[1]  = '{5, 1, 2, 5, 0, 1, 0, 1};  // 5 samples, play -> PLAY len 5
    vec[2]  = '{0, 2, 2, 5, 0, 1, 1, 1};  // rev toggles on
    vec[3]  = '{2, 1, 3, 5, 0, 0, 1, 1};  // play -> STOP, reverse kept
    vec[4]  = '{2, 2, 3, 5, 0, 0, 1, 1};  // rev ignored in STOP
    vec[5]  = '{0, 1, 2, 5, 0, 1, 1, 1};  // play -> PLAY
    vec[6]  = '{1, 0, 1, 5, 1, 0, 0, 1};  // overdub keeps len, clears reverse
    vec[7]  = '{3, 1, 2, 5, 0, 1, 0, 1};  // short overdub does not shrink
    vec[8]  = '{0, 0, 1, 5, 1, 0, 0, 1};  // overdub again
    vec[9]  = '{7, 1, 2, 7, 0, 1, 0, 1};  // 2 samples past old end
    vec[10] = '{0, 1, 3, 7, 0, 0, 0, 1};  // STOP
    vec[11] = '{0, 0, 1, 0, 1, 0, 0, 0};  // new loop from STOP clears len
    vec[12] = '{0, 1, 0, 0, 0, 0, 0, 0};  // empty take -> IDLE
    vec[13] = '{0, 1, 0, 0, 0, 0, 0, 0};  // play ignored in IDLE
    vec[14] = '{0, 2, 0, 0, 0, 0, 0, 0};  // rev ignored in IDLE
    vec[15] = '{0, 0, 1, 0, 1, 0, 0, 0};  // rec -> RECORD
    vec[16] = '{4, 0, 2, 4, 0, 1, 0, 1};  // rec in RECORD also ends take

    lp.sample_tick = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_exp("reset_state", 0, 0, 0, 0, 0, 0);
    check_bit("reset_step", lp.rw_step, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      tick_en = 1'b1;
      repeat (3 * vec[i].ticks) cycle();
      tick_en = 1'b0;
      press_key(vec[i].key);
      check_exp($sformatf("vec%0d", i), vec[i].st, vec[i].len,
                vec[i].w, vec[i].r, vec[i].rev, vec[i].ex);
    end

    // Reset asserted mid-record clears everything without waiting for clk.
    press_key(0);
    tick_en = 1'b1;
    repeat (7) cycle();
    #2 reset = 1'b0;
    #1;
    check_exp("reset_async", 0, 0, 0, 0, 0, 0);
    check_bit("reset_async_step", lp.rw_step, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (12) cycle();
    check_exp("post_reset_idle", 0, 0, 0, 0, 0, 0);

    // Bounce 1-0-1 then held: a single accepted press.
    tick_en = 1'b0;
    set_keys(3'b001); cycle();
    set_keys(3'b000); cycle();
    set_keys(3'b001); cycle();
    repeat (4) cycle();
    set_keys(3'b000);
    repeat (DB + 8) cycle();
    check_exp("bounce_one_press", 1, 0, 1, 0, 0, 0);

    // Fill the memory: the 8th sample forces PLAY.
    tick_en = 1'b1;
    ntick = 0;
    while (ntick < 8) begin
      cycle();
      if (lp.sample_tick) ntick++;
    end
    check_exp("auto_play", 2, 8, 0, 1, 0, 1);
    check_bit("auto_step8", lp.rw_step, 1'b1);
    while (ntick < 9) begin
      cycle();
      if (lp.sample_tick) ntick++;
    end
    check_bit("tick9_step", lp.rw_step, 1'b1);
    check_exp("tick9_len", 2, 8, 0, 1, 0, 1);

    // Random keys, including short glitches and simultaneous presses.
    for (int n = 0; n < 250; n++) begin
      logic [2:0] m;
      tick_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) m = 3'($urandom_range(1, 7));
      else m = 3'b001 << $urandom_range(0, 2);
      set_keys(m);
      repeat ($urandom_range(1, DB + 3)) cycle();
      set_keys(3'b000);
      repeat ($urandom_range(1, DB + 8)) cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule : tb_looper_ctrl
`default_nettype wire

// File: doc/looper_ctrl.md
# looper_ctrl

Control front end for the audio looper. Converts three raw pushbuttons and the codec's per-sample strobe into the looper's `write`, `read` and `reverse` levels and its sample-rate step strobe. It tracks recorded loop length and enforces the rules the datapath relies on:

- never read and write together;
- never reverse while recording;
- never read before a loop exists.

It sits directly upstream of the looper datapath, between the board keys/codec handshake and the looper.

## Interface
Parameters:
- `ADDR_WIDTH`, 15: loop memory address width; maximum loop is 2**ADDR_WIDTH samples.
- `DEBOUNCE_CYCLES`, 50000: clk cycles a synchronized key must hold a new level before it is accepted.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `key_rec`  in  1  raw record button, active-high, asynchronous to clk.
- `key_play`  in  1  raw play/stop button, active-high, asynchronous.
- `key_rev`  in  1  raw reverse toggle button, active-high, asynchronous.
- `sample_tick`  in  1  one-cycle strobe per audio sample (codec read_ready & write_ready).
- `write`  out  1  record level to looper.
- `read`  out  1  playback level to looper.
- `reverse`  out  1  reverse-playback level to looper.
- `rw_step`  out  1  one-cycle strobe: advance looper address this cycle.
- `loop_len`  out  ADDR_WIDTH+1  recorded length in samples; 0 means no loop.
- `loop_exists`  out  1  high once `loop_len` is nonzero.
- `state`  out  2  current FSM state, for LEDs.

## Operation
- Each key passes through a 2-flop synchronizer and a debounce counter.
  - The counter resets whenever the synchronized level equals the accepted level.
  - The accepted level flips after DEBOUNCE_CYCLES consecutive differing cycles.
  - A rising edge of the accepted level gives a one-cycle press pulse.
- FSM states: IDLE=0, RECORD=1, PLAY=2, STOP=3.
- IDLE:
  - rec press → RECORD, clearing `loop_len` to 0.
  - play/rev presses are ignored.
- RECORD:
  - `write`=1.
  - Each `sample_tick` raises `rw_step` and increments `loop_len`.
  - rec or play press → PLAY.
  - `loop_len` reaching 2**ADDR_WIDTH → PLAY automatically; no further increment.
  - If `loop_len` is 0 when leaving, go to IDLE instead of PLAY.
- PLAY:
  - `read`=1; `rw_step` follows `sample_tick`.
  - play press → STOP.
  - rec press → RECORD (overdub; `loop_len` is NOT cleared).
  - rev press toggles `reverse`.
- STOP:
  - `read`=0, `write`=0; `rw_step` held 0.
  - play press → PLAY.
  - rec press → RECORD with `loop_len` cleared (new loop).
- Overdub in RECORD with `loop_len` nonzero: `loop_len` increments only while `loop_len` is below its pre-overdub value plus new samples past the old end. In practice: overdub never shrinks the loop; increment only when the step position reaches `loop_len`.
  - A position counter (ADDR_WIDTH bits) tracks the step index. It resets to 0 on entering RECORD and wraps at `loop_len` during PLAY.
- `reverse`:
  - Forced 0 in RECORD and IDLE; retained through STOP.
  - Cleared on entering RECORD.
- Presses arriving in the same cycle: rec has priority over play; rev is evaluated independently.

## Timing
- All outputs are registered.
- Reset values: `write`=0, `read`=0, `reverse`=0, `rw_step`=0, `loop_len`=0, `loop_exists`=0, `state`=IDLE. Debounce accepted levels are 0.
- Key to press pulse: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Press pulse to new state and level outputs: 1 cycle.
- `rw_step` is `sample_tick` delayed by exactly 1 cycle, gated by the state at the tick cycle.
- A `sample_tick` coinciding with a state-changing press steps under the old state.
- `write` and `read` are never both high. On RECORD↔PLAY the change is atomic in one cycle.
- Reset asserted mid-record returns everything to reset values immediately. Loop content is considered lost (`loop_len`=0).

## Structure
- `looper_pkg`:
  - `state_t` enum (IDLE, RECORD, PLAY, STOP).
  - Default `ADDR_WIDTH`.
  - Shared by looper_ctrl and the looper datapath.
- Sub-module `key_debounce` (synchronizer + counter + edge pulse), parameterized by DEBOUNCE_CYCLES, instantiated three times.

## Test plan
Use ADDR_WIDTH=3, DEBOUNCE_CYCLES=4, and `sample_tick` every 3 cycles.

- Reset low mid-run → all outputs 0, `state`=0 within the same cycle; hold 0 after release until a press.
- Key bounce 1-0-1 over 3 cycles, then held high 4 cycles → exactly one press pulse; IDLE→RECORD 1 cycle later, `write`=1.
- Rec, 5 ticks, play press → `loop_len`=5, `write` falls and `read` rises in the same cycle, `state`=2.
- Rec held through 8 ticks → auto PLAY with `loop_len`=8; a 9th tick gives `rw_step` with `read`=1 and `loop_len` stays 8.
- In PLAY, rev press → `reverse`=1; play press → STOP, `reverse` stays 1, `rw_step` silent; rec press → RECORD, `reverse`=0, `loop_len`=0.
- Rec press from IDLE then immediate play press with no tick → IDLE, `loop_exists`=0; play/rev presses in IDLE cause no change.
